dcache_tag_arbiter: RTL
=======================

# dcache_tag_arbiter

Parametrised N-port, M-way arbiter and tag comparator between the data-cache controllers/miss handler and the per-way tag/data/valid-dirty SRAMs of the nonblocking L1 data cache. Port 0 (miss handler) has fixed top priority, and ports 1..NR_PORTS-1 are served round-robin. Hit-way detection is registered against the SRAM read of the previous cycle. The block adds a self-timed invalidation sweep after reset or on request, so every valid/dirty bit is cleared before any port is granted.

## Interface
Parameters:
- NR_PORTS, 4: requesting ports; port 0 has fixed priority. Legal range 2..8.
- SET_ASSOC, 8: ways.
- INDEX_WIDTH, 12: index incl. byte offset.
- BYTE_OFFSET, 4: line offset bits; NUM_WORDS = 2^(INDEX_WIDTH-BYTE_OFFSET).
- TAG_WIDTH, 44: tag bits.
- LINE_WIDTH, 128: data bits per line.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- init_start_i  in  1  request an invalidation sweep.
- init_busy_o  out  1  sweep in progress.
- req_i  in  NR_PORTS x SET_ASSOC  per-port way-select request; port requests when any bit is set.
- addr_i  in  NR_PORTS x INDEX_WIDTH  index.
- we_i  in  NR_PORTS  write.
- wtag_i / wdata_i / wvalid_i / wdirty_i  in  NR_PORTS x (TAG_WIDTH / LINE_WIDTH / 1 / 1)  write payload.
- be_tag_i / be_data_i / be_vd_i  in  NR_PORTS x (TAG_WIDTH / LINE_WIDTH/8 / SET_ASSOC)  byte enables; be_vd_i holds one bit per way.
- tag_i  in  NR_PORTS x TAG_WIDTH  compare tag, sampled the cycle after grant.
- gnt_o  out  NR_PORTS  grant, one-hot or zero.
- rtag_o / rline_o / rvalid_o / rdirty_o  out  SET_ASSOC x (TAG_WIDTH / LINE_WIDTH / 1 / 1)  read data, passed through from the SRAMs.
- hit_way_o  out  SET_ASSOC  hit vector for the previous grant.
- hit_valid_o  out  1  hit_way_o is valid for the previous read grant.
- ram_req_o  out  SET_ASSOC  per-way SRAM enable.
- ram_we_o  out  1  SRAM write enable.
- ram_addr_o  out  INDEX_WIDTH-BYTE_OFFSET  SRAM word address.
- ram_wtag_o / ram_wline_o / ram_wvalid_o / ram_wdirty_o / ram_be_tag_o / ram_be_data_o / ram_be_vd_o  out  (widths as the matching inputs)  SRAM write payload and enables.
- ram_rtag_i / ram_rline_i / ram_rvalid_i / ram_rdirty_i  in  SET_ASSOC x (widths as outputs)  SRAM read data, one-cycle latency.

## Operation
- FSM states: SWEEP, IDLE.
  - rst_i forces SWEEP with sweep counter = 0 and rr_ptr = 1.
  - IDLE -> SWEEP when init_start_i = 1. The counter restarts at 0.
  - SWEEP -> IDLE in the cycle after the counter reaches NUM_WORDS-1.
  - init_start_i is ignored while in SWEEP.
- SWEEP:
  - Drive ram_req_o = all ones, ram_we_o = 1, ram_addr_o = counter.
  - Drive ram_wvalid_o = 0, ram_wdirty_o = 0, ram_be_vd_o = all ones, and all other byte enables = 0.
  - Counter increments by 1 per cycle.
  - gnt_o = 0 and init_busy_o = 1.
- IDLE arbitration is combinational and takes effect in the same cycle as the request:
  - If port 0 requests, it is granted.
  - Otherwise grant the first requesting port among 1..NR_PORTS-1, searching from rr_ptr upward with wrap-around from NR_PORTS-1 to 1.
  - After a grant to port k >= 1, rr_ptr becomes k+1, wrapping from NR_PORTS-1 to 1.
  - A grant to port 0 leaves rr_ptr unchanged.
- SRAM mux: the granted port drives ram_req_o = its req_i, ram_we_o, ram_addr_o = addr_i[INDEX_WIDTH-1:BYTE_OFFSET], and all of its payload and enables. With no grant, ram_req_o = 0.
- Compare registers: a granted read (we_i = 0) registers the port id (id_q) and sets rd_q = 1. A write, or no grant, clears rd_q.
- Hit detection, in the following cycle:
  - hit_way_o[i] = rd_q & ram_rvalid_i[i] & (ram_rtag_i[i] == tag_i[id_q]).
  - hit_valid_o = rd_q.
  - With multiple hits, hit_way_o reports all of them and a simulation assertion fires.
- rtag_o, rline_o, rvalid_o and rdirty_o are combinational pass-throughs from the SRAM read inputs.

## Timing
- Reset values (with rst_i asserted):
  - gnt_o = 0, hit_way_o = 0, hit_valid_o = 0, ram_req_o = all ones, ram_we_o = 1, init_busy_o = 1.
  - Internally: counter = 0, rr_ptr = 1, rd_q = 0.
- Sweep length: exactly NUM_WORDS cycles of SWEEP after rst_i deasserts. The first grant is possible in the cycle after the last sweep write.
- Handshakes:
  - Grant is in the same cycle as the request.
  - Read data and hit result appear 1 cycle after grant.
  - A port must hold tag_i for that cycle.
  - Requests not granted must be held; there is no queueing.
- Back-to-back grants are allowed every cycle. hit_valid_o may therefore be high in consecutive cycles for different ports.
- Asserting rst_i mid-sweep or mid-read aborts: it returns to SWEEP at counter 0 and drops rd_q.
- init_start_i arriving in the same cycle as a request: the request is granted this cycle and SWEEP begins next cycle. hit_valid_o for that grant still fires during the first SWEEP cycle.

## Test plan
- Reset sweep, NUM_WORDS = 256: deassert rst_i → expect 256 cycles with ram_we_o = 1, ram_addr_o stepping 0..255, be_vd = 0xFF, gnt_o = 0; then init_busy_o = 0 and the first request is granted.
- Priority: ports 0, 1 and 3 all request → gnt_o = 0001. With port 0 held, port 0 is granted again and rr_ptr is unchanged.
- Round robin with NR_PORTS = 4: ports 1–3 request continuously → grant sequence 1, 2, 3, 1, 2.
- Hit detection: write tag 0x123 valid=1 to way 2 at index 5; then read index 5 with tag_i = 0x123 → next cycle hit_way_o = 0x04, hit_valid_o = 1. Tag 0x124 → hit_way_o = 0.
- Re-init: set valid in way 0 at index 7, pulse init_start_i, wait for the sweep to finish, read index 7 → rvalid_o = 0 and hit_way_o = 0.
- Reset at sweep counter 100 → after release, the sweep restarts at address 0 and lasts the full 256 cycles.

Source files
------------

// File: rtl/dcache_tag_arbiter.sv
// Port arbiter and registered tag comparator in front of the per-way L1 data-cache SRAMs.
// After reset or on request, an invalidation sweep clears every valid/dirty bit before any port is granted.
module dcache_tag_arbiter #(
    parameter int unsigned NR_PORTS    = 4,
    parameter int unsigned SET_ASSOC   = 8,
    parameter int unsigned INDEX_WIDTH = 12,
    parameter int unsigned BYTE_OFFSET = 4,
    parameter int unsigned TAG_WIDTH   = 44,
    parameter int unsigned LINE_WIDTH  = 128
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          init_start_i,
    output logic                                          init_busy_o,
    input  logic [NR_PORTS-1:0][SET_ASSOC-1:0]            req_i,
    input  logic [NR_PORTS-1:0][INDEX_WIDTH-1:0]          addr_i,
    input  logic [NR_PORTS-1:0]                           we_i,
    input  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]            wtag_i,
    input  logic [NR_PORTS-1:0][LINE_WIDTH-1:0]           wdata_i,
    input  logic [NR_PORTS-1:0]                           wvalid_i,
    input  logic [NR_PORTS-1:0]                           wdirty_i,
    input  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]            be_tag_i,
    input  logic [NR_PORTS-1:0][LINE_WIDTH/8-1:0]         be_data_i,
    input  logic [NR_PORTS-1:0][SET_ASSOC-1:0]            be_vd_i,
    input  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]            tag_i,
    output logic [NR_PORTS-1:0]                           gnt_o,
    output logic [SET_ASSOC-1:0][TAG_WIDTH-1:0]           rtag_o,
    output logic [SET_ASSOC-1:0][LINE_WIDTH-1:0]          rline_o,
    output logic [SET_ASSOC-1:0]                          rvalid_o,
    output logic [SET_ASSOC-1:0]                          rdirty_o,
    output logic [SET_ASSOC-1:0]                          hit_way_o,
    output logic                                          hit_valid_o,
    output logic [SET_ASSOC-1:0]                          ram_req_o,
    output logic                                          ram_we_o,
    output logic [INDEX_WIDTH-BYTE_OFFSET-1:0]            ram_addr_o,
    output logic [TAG_WIDTH-1:0]                          ram_wtag_o,
    output logic [LINE_WIDTH-1:0]                         ram_wline_o,
    output logic                                          ram_wvalid_o,
    output logic                                          ram_wdirty_o,
    output logic [TAG_WIDTH-1:0]                          ram_be_tag_o,
    output logic [LINE_WIDTH/8-1:0]                       ram_be_data_o,
    output logic [SET_ASSOC-1:0]                          ram_be_vd_o,
    input  logic [SET_ASSOC-1:0][TAG_WIDTH-1:0]           ram_rtag_i,
    input  logic [SET_ASSOC-1:0][LINE_WIDTH-1:0]          ram_rline_i,
    input  logic [SET_ASSOC-1:0]                          ram_rvalid_i,
    input  logic [SET_ASSOC-1:0]                          ram_rdirty_i
);

    localparam int unsigned WORD_W = INDEX_WIDTH - BYTE_OFFSET;
    localparam int unsigned PW     = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]       id_q, id_d;
    logic                rd_q, rd_d;

    logic [NR_PORTS-1:0] port_req;
    logic                gnt_any;
    logic [PW-1:0]       gnt_idx;
    int unsigned         cand;

    // Only the index bits above the line offset address the SRAM word.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^addr_i;

    always_comb begin
        port_req = '0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            port_req[p] = |req_i[p];
        end
    end

    // Port 0 always wins; the others are searched from rr_ptr upward, wrapping back to port 1.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        if (state_q == ST_IDLE) begin
            if (port_req[0]) begin
                gnt_any = 1'b1;
            end else begin
                for (int unsigned off = 0; off < NR_PORTS - 1; off++) begin
                    cand = 32'(rr_ptr_q) + off;
                    if (cand >= NR_PORTS) begin
                        cand = cand - (NR_PORTS - 1);
                    end
                    if (!gnt_any && port_req[PW'(cand)]) begin
                        gnt_any = 1'b1;
                        gnt_idx = PW'(cand);
                    end
                end
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (gnt_any) begin
            gnt_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ram_req_o     = '0;
        ram_we_o      = 1'b0;
        ram_addr_o    = '0;
        ram_wtag_o    = '0;
        ram_wline_o   = '0;
        ram_wvalid_o  = 1'b0;
        ram_wdirty_o  = 1'b0;
        ram_be_tag_o  = '0;
        ram_be_data_o = '0;
        ram_be_vd_o   = '0;
        if (state_q == ST_SWEEP) begin
            ram_req_o   = '1;
            ram_we_o    = 1'b1;
            ram_addr_o  = cnt_q;
            ram_be_vd_o = '1;
        end else if (gnt_any) begin
            ram_req_o     = req_i[gnt_idx];
            ram_we_o      = we_i[gnt_idx];
            ram_addr_o    = addr_i[gnt_idx][INDEX_WIDTH-1:BYTE_OFFSET];
            ram_wtag_o    = wtag_i[gnt_idx];
            ram_wline_o   = wdata_i[gnt_idx];
            ram_wvalid_o  = wvalid_i[gnt_idx];
            ram_wdirty_o  = wdirty_i[gnt_idx];
            ram_be_tag_o  = be_tag_i[gnt_idx];
            ram_be_data_o = be_data_i[gnt_idx];
            ram_be_vd_o   = be_vd_i[gnt_idx];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        rd_d     = 1'b0;
        case (state_q)
            ST_SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // A grant in the same cycle as init_start_i still completes its compare.
                if (init_start_i) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
                if (gnt_any && !we_i[gnt_idx]) begin
                    rd_d = 1'b1;
                    id_d = gnt_idx;
                end
                if (gnt_any && (gnt_idx != '0)) begin
                    rr_ptr_d = (gnt_idx == PW'(NR_PORTS - 1)) ? PW'(1) : gnt_idx + PW'(1);
                end
            end
            default: begin
                state_d = ST_SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_SWEEP;
            cnt_q    <= '0;
            rr_ptr_q <= PW'(1);
            id_q     <= '0;
            rd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            rd_q     <= rd_d;
        end
    end

    assign init_busy_o = (state_q == ST_SWEEP);

    // Compare against the SRAM read launched by last cycle's grant.
    always_comb begin
        hit_way_o = '0;
        for (int unsigned w = 0; w < SET_ASSOC; w++) begin
            hit_way_o[w] = rd_q & ram_rvalid_i[w] & (ram_rtag_i[w] == tag_i[id_q]);
        end
    end

    assign hit_valid_o = rd_q;

    assign rtag_o   = ram_rtag_i;
    assign rline_o  = ram_rline_i;
    assign rvalid_o = ram_rvalid_i;
    assign rdirty_o = ram_rdirty_i;

    a_hit_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(hit_way_o));

endmodule
